hex_scroll_ctrl: RTL and testbench

Scroll controller for the eight-digit seven-segment display path. It holds a short message of 4-bit character codes and shifts them across a 32-bit digit window, one digit per scroll tick. It supports run, pause and single-step control. The 32-bit window output feeds the existing per-digit decoders directly, with Q[3:0] driving HEX0 and Q[31:28] driving HEX7.

---
 rtl/hex_scroll_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hex_scroll_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scroll_ctrl.sv
`timescale 1ns/1ps
// hex_scroll_ctrl
//   Scroll controller for the eight-digit seven-segment display path. A small
//   message buffer of 4-bit character codes is shifted into a 32-bit digit
//   window, one digit per scroll tick. Characters enter at HEX0 (q[3:0]) and
//   move toward HEX7 (q[31:28]). Supports run, pause and single-step.
//
//   Optional feature macro: SCROLL_GAP_EN
//     When defined, eight blank digits are inserted after the last message
//     character before the message repeats.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   wr_en    write wr_data into buffer[wr_addr]
//   wr_addr  buffer address (bits above log2(DEPTH) ignored)
//   wr_data  character code
//   msg_len  message length, sampled on an accepted start (1..DEPTH)
//   start    begin / restart scrolling
//   stop     return to idle, blank the window
//   pause    toggle run / paused
//   step     one shift while paused
//   q        32-bit digit window (registered)
//   busy     high while running or paused (registered)
//   wrap     one-cycle pulse after the shift consuming the last character
module hex_scroll_ctrl #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter logic [3:0]  BLANK_CODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [3:0]  wr_data,
    input  logic [4:0]  msg_len,
    input  logic        start,
    input  logic        stop,
    input  logic        pause,
    input  logic        step,
    output logic [31:0] q,
    output logic        busy,
    output logic        wrap
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [4:0]  LEN_MAX  = 5'(DEPTH);
    localparam logic [31:0] BLANKS   = {8{BLANK_CODE}};

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t        state;
    logic [3:0]    buffer [0:(1<<AW)-1];
    logic [AW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic [4:0]    len;

    logic          start_ok;
    logic          last;
    logic          shift_now;
    logic [3:0]    shift_char;
    logic [AW-1:0] ptr_next;
    logic          wrap_next;
    logic          unused_addr_bits;

`ifdef SCROLL_GAP_EN
    logic [3:0]    gap_cnt;
    logic          in_gap;
    assign in_gap = (gap_cnt != 4'd0);
`endif

    assign unused_addr_bits = ^wr_addr;

    // Buffer is deliberately not reset; writes are allowed in any state.
    always_ff @(posedge clk) begin
        if (wr_en)
            buffer[wr_addr[AW-1:0]] <= wr_data;
    end

    assign start_ok = start && (msg_len != 5'd0) && (msg_len <= LEN_MAX);
    assign last     = ({{(5-AW){1'b0}}, ptr} == (len - 5'd1));

    // A shift only happens when no higher-priority control is active this
    // cycle: step while paused, or counter terminal count while running.
    assign shift_now = !start_ok && !stop && !pause &&
                       (((state == PAUSED) && step) ||
                        ((state == RUN) && (cnt == CNT_LAST)));

    always_comb begin
        shift_char = buffer[ptr];
        ptr_next   = last ? '0 : ptr + AW'(1);
        wrap_next  = last;
`ifdef SCROLL_GAP_EN
        if (in_gap) begin
            shift_char = BLANK_CODE;
            ptr_next   = ptr;
            wrap_next  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            q       <= BLANKS;
            ptr     <= '0;
            cnt     <= '0;
            len     <= '0;
            busy    <= 1'b0;
            wrap    <= 1'b0;
`ifdef SCROLL_GAP_EN
            gap_cnt <= '0;
`endif
        end else begin
            wrap <= 1'b0;
            if (start_ok) begin
                state   <= RUN;
                len     <= msg_len;
                ptr     <= '0;
                cnt     <= '0;
                q       <= BLANKS;
                busy    <= 1'b1;
`ifdef SCROLL_GAP_EN
                gap_cnt <= '0;
`endif
            end else if (stop) begin
                state   <= IDLE;
                ptr     <= '0;
                cnt     <= '0;
                q       <= BLANKS;
                busy    <= 1'b0;
`ifdef SCROLL_GAP_EN
                gap_cnt <= '0;
`endif
            end else if (pause) begin
                // Counter holds across both transitions.
                if (state == RUN)
                    state <= PAUSED;
                else if (state == PAUSED)
                    state <= RUN;
            end else begin
                if (state == RUN)
                    cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
                if (shift_now) begin
                    q    <= {q[27:0], shift_char};
                    ptr  <= ptr_next;
                    wrap <= wrap_next;
`ifdef SCROLL_GAP_EN
                    if (in_gap)
                        gap_cnt <= gap_cnt - 4'd1;
                    else if (last)
                        gap_cnt <= 4'd8;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
`timescale 1ns/1ps
module tb_hex_scroll_ctrl;

    localparam int unsigned TICK = 4;
    localparam logic [31:0] BLANKS = 32'hFFFF_FFFF;
    localparam logic [3:0]  C_START = 4'b1000;
    localparam logic [3:0]  C_STOP  = 4'b0100;
    localparam logic [3:0]  C_PAUSE = 4'b0010;
    localparam logic [3:0]  C_STEP  = 4'b0001;

`ifdef SCROLL_GAP_EN
    localparam logic [31:0] Q6  = 32'hFF01_223F;
    localparam logic [31:0] Q7  = 32'hF012_23FF;
    localparam logic [31:0] Q8  = 32'h0122_3FFF;
    localparam logic [31:0] Q9  = 32'h1223_FFFF;
    localparam logic [31:0] Q10 = 32'h223F_FFFF;
    localparam logic        W10 = 1'b0;
    localparam logic [31:0] R4  = 32'hFFFF_012F;
`else
    localparam logic [31:0] Q6  = 32'hFF01_2230;
    localparam logic [31:0] Q7  = 32'hF012_2301;
    localparam logic [31:0] Q8  = 32'h0122_3012;
    localparam logic [31:0] Q9  = 32'h1223_0122;
    localparam logic [31:0] Q10 = 32'h2230_1223;
    localparam logic        W10 = 1'b1;
    localparam logic [31:0] R4  = 32'hFFFF_0120;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [3:0]  wr_data = '0;
    logic [4:0]  msg_len = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic        step = 1'b0;
    logic [31:0] q;
    logic        busy;
    logic        wrap;

    int vectors = 0;
    int miscompares = 0;

    // One scoreboard entry: control pulses for the first cycle, number of
    // cycles to advance, then the expected registered outputs.
    typedef struct {
        string       name;
        logic [3:0]  ctl;
        int          dly;
        logic [31:0] q;
        logic        busy;
        logic        wrap;
    } vec_t;

    vec_t sb[$];

    hex_scroll_ctrl #(
        .DEPTH      (16),
        .TICK_DIV   (TICK),
        .BLANK_CODE (4'hF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .msg_len (msg_len),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .step    (step),
        .q       (q),
        .busy    (busy),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string name, input logic [3:0] ctl, input int dly,
                        input logic [31:0] eq, input logic eb, input logic ew);
        vec_t v;
        v.name = name; v.ctl = ctl; v.dly = dly;
        v.q = eq; v.busy = eb; v.wrap = ew;
        sb.push_back(v);
    endtask

    task automatic test_reset;
        vec_t v;
        rst = 1'b1;
        cyc(2);
        push("reset_init", 4'b0000, 0, BLANKS, 1'b0, 1'b0);
        while (sb.size() > 0) begin
            v = sb.pop_front();
            cyc(v.dly);
            vectors++;
            if (q !== v.q || busy !== v.busy || wrap !== v.wrap) begin
                miscompares++;
                $display("FAIL %s: got Q=%h busy=%b wrap=%b, expected Q=%h busy=%b wrap=%b",
                         v.name, q, busy, wrap, v.q, v.busy, v.wrap);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_scroll;
        vec_t v;
        logic [3:0] msg [5];
        msg = '{4'h0, 4'h1, 4'h2, 4'h2, 4'h3};
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = msg[i];
            cyc(1);
        end
        wr_en = 1'b0;
        msg_len = 5'd5;
        push("start_blank",   C_START, 1, BLANKS,        1'b1, 1'b0);
        push("cnt3_blank",    4'b0000, 3, BLANKS,        1'b1, 1'b0);
        push("shift1",        4'b0000, 1, 32'hFFFFFFF0,  1'b1, 1'b0);
        push("shift2",        4'b0000, 4, 32'hFFFFFF01,  1'b1, 1'b0);
        push("shift3",        4'b0000, 4, 32'hFFFFF012,  1'b1, 1'b0);
        push("shift4",        4'b0000, 4, 32'hFFFF0122,  1'b1, 1'b0);
        push("shift5_wrap",   4'b0000, 4, 32'hFFF01223,  1'b1, 1'b1);
        push("wrap_drop",     4'b0000, 1, 32'hFFF01223,  1'b1, 1'b0);
        push("shift6",        4'b0000, 3, Q6,            1'b1, 1'b0);
        while (sb.size() > 0) begin
            v = sb.pop_front();
            {start, stop, pause, step} = v.ctl;
            if (v.dly > 0) begin
                cyc(1);
                {start, stop, pause, step} = 4'b0000;
                cyc(v.dly - 1);
            end
            vectors++;
            if (q !== v.q || busy !== v.busy || wrap !== v.wrap) begin
                miscompares++;
                $display("FAIL %s: got Q=%h busy=%b wrap=%b, expected Q=%h busy=%b wrap=%b",
                         v.name, q, busy, wrap, v.q, v.busy, v.wrap);
            end
        end
    endtask

    task automatic test_pause_step;
        vec_t v;
        push("run_cnt1",        4'b0000, 1,  Q6, 1'b1, 1'b0);
        push("pause_in",        C_PAUSE, 1,  Q6, 1'b1, 1'b0);
        push("paused_hold20",   4'b0000, 20, Q6, 1'b1, 1'b0);
        push("step1",           C_STEP,  1,  Q7, 1'b1, 1'b0);
        push("step2",           C_STEP,  1,  Q8, 1'b1, 1'b0);
        push("paused_no_more",  4'b0000, 5,  Q8, 1'b1, 1'b0);
        push("resume",          C_PAUSE, 1,  Q8, 1'b1, 1'b0);
        push("resume_cnt3",     4'b0000, 2,  Q8, 1'b1, 1'b0);
        push("resume_shift",    4'b0000, 1,  Q9, 1'b1, 1'b0);
        while (sb.size() > 0) begin
            v = sb.pop_front();
            {start, stop, pause, step} = v.ctl;
            if (v.dly > 0) begin
                cyc(1);
                {start, stop, pause, step} = 4'b0000;
                cyc(v.dly - 1);
            end
            vectors++;
            if (q !== v.q || busy !== v.busy || wrap !== v.wrap) begin
                miscompares++;
                $display("FAIL %s: got Q=%h busy=%b wrap=%b, expected Q=%h busy=%b wrap=%b",
                         v.name, q, busy, wrap, v.q, v.busy, v.wrap);
            end
        end
    endtask

    task automatic test_simultaneous;
        vec_t v;
        push("sim_cnt1",        4'b0000,          1, Q9,  1'b1, 1'b0);
        push("sim_pause",       C_PAUSE,          1, Q9,  1'b1, 1'b0);
        push("pause_step_same", C_PAUSE | C_STEP, 1, Q9,  1'b1, 1'b0);
        push("sim_cnt3",        4'b0000,          2, Q9,  1'b1, 1'b0);
        push("sim_run_shift",   4'b0000,          1, Q10, 1'b1, W10);
        while (sb.size() > 0) begin
            v = sb.pop_front();
            {start, stop, pause, step} = v.ctl;
            if (v.dly > 0) begin
                cyc(1);
                {start, stop, pause, step} = 4'b0000;
                cyc(v.dly - 1);
            end
            vectors++;
            if (q !== v.q || busy !== v.busy || wrap !== v.wrap) begin
                miscompares++;
                $display("FAIL %s: got Q=%h busy=%b wrap=%b, expected Q=%h busy=%b wrap=%b",
                         v.name, q, busy, wrap, v.q, v.busy, v.wrap);
            end
        end
    endtask

    task automatic test_invalid_restart;
        vec_t v;
        for (int phase = 0; phase < 5; phase++) begin
            case (phase)
                0: begin
                    msg_len = 5'd0;
                    push("stop_idle",    C_STOP,  1, BLANKS, 1'b0, 1'b0);
                    push("start_len0",   C_START, 1, BLANKS, 1'b0, 1'b0);
                    push("idle_len0",    4'b0000, 6, BLANKS, 1'b0, 1'b0);
                end
                1: begin
                    msg_len = 5'd17;
                    push("start_len17",  C_START, 1, BLANKS, 1'b0, 1'b0);
                    push("idle_len17",   4'b0000, 5, BLANKS, 1'b0, 1'b0);
                end
                2: begin
                    msg_len = 5'd5;
                    push("start_len5",   C_START, 1, BLANKS,       1'b1, 1'b0);
                    push("len5_shift1",  4'b0000, 4, 32'hFFFFFFF0, 1'b1, 1'b0);
                    push("len5_shift2",  4'b0000, 4, 32'hFFFFFF01, 1'b1, 1'b0);
                    push("len5_cnt2",    4'b0000, 2, 32'hFFFFFF01, 1'b1, 1'b0);
                end
                3: begin
                    msg_len = 5'd3;
                    push("restart_blank", C_START, 1, BLANKS, 1'b1, 1'b0);
                end
                default: begin
                    msg_len = 5'd5;
                    push("restart_cnt3",  4'b0000, 3, BLANKS,       1'b1, 1'b0);
                    push("restart_sh1",   4'b0000, 1, 32'hFFFFFFF0, 1'b1, 1'b0);
                    push("restart_sh2",   4'b0000, 4, 32'hFFFFFF01, 1'b1, 1'b0);
                    push("restart_wrap3", 4'b0000, 4, 32'hFFFFF012, 1'b1, 1'b1);
                    push("restart_sh4",   4'b0000, 4, R4,           1'b1, 1'b0);
                end
            endcase
            while (sb.size() > 0) begin
                v = sb.pop_front();
                {start, stop, pause, step} = v.ctl;
                if (v.dly > 0) begin
                    cyc(1);
                    {start, stop, pause, step} = 4'b0000;
                    cyc(v.dly - 1);
                end
                vectors++;
                if (q !== v.q || busy !== v.busy || wrap !== v.wrap) begin
                    miscompares++;
                    $display("FAIL %s: got Q=%h busy=%b wrap=%b, expected Q=%h busy=%b wrap=%b",
                             v.name, q, busy, wrap, v.q, v.busy, v.wrap);
                end
            end
        end
    endtask

    // Returns the window value left behind, for the reset test.
    task automatic test_write_hazard(output logic [31:0] final_q);
        vec_t v;
        logic [31:0] exp_q;
        for (int phase = 0; phase < 3; phase++) begin
            case (phase)
                0: begin
                    msg_len = 5'd3;
                    push("hz_stop",   C_STOP,  1, BLANKS, 1'b0, 1'b0);
                    push("hz_start",  C_START, 1, BLANKS, 1'b1, 1'b0);
                    push("hz_cnt3",   4'b0000, 3, BLANKS, 1'b1, 1'b0);
                end
                1: begin
                    wr_en = 1'b1; wr_addr = 4'h0; wr_data = 4'h9;
                    push("hazard_old", 4'b0000, 1, 32'hFFFFFFF0, 1'b1, 1'b0);
                end
                default: begin
                    push("hz_sh2",       4'b0000, 4, 32'hFFFFFF01, 1'b1, 1'b0);
                    push("hz_wrap",      4'b0000, 4, 32'hFFFFF012, 1'b1, 1'b1);
                    exp_q = 32'hFFFFF012;
`ifdef SCROLL_GAP_EN
                    for (int k = 0; k < 8; k++) begin
                        exp_q = {exp_q[27:0], 4'hF};
                        push("gap_blank", 4'b0000, 4, exp_q, 1'b1, 1'b0);
                    end
`endif
                    exp_q = {exp_q[27:0], 4'h9};
                    push("hazard_new",   4'b0000, 4, exp_q, 1'b1, 1'b0);
                end
            endcase
            while (sb.size() > 0) begin
                v = sb.pop_front();
                {start, stop, pause, step} = v.ctl;
                if (v.dly > 0) begin
                    cyc(1);
                    {start, stop, pause, step} = 4'b0000;
                    wr_en = 1'b0;
                    cyc(v.dly - 1);
                end
                vectors++;
                if (q !== v.q || busy !== v.busy || wrap !== v.wrap) begin
                    miscompares++;
                    $display("FAIL %s: got Q=%h busy=%b wrap=%b, expected Q=%h busy=%b wrap=%b",
                             v.name, q, busy, wrap, v.q, v.busy, v.wrap);
                end
            end
        end
        final_q = exp_q;
    endtask

    task automatic test_reset_midrun(input logic [31:0] run_q);
        vec_t v;
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 0) begin
                push("midrun_before", 4'b0000, 2, run_q, 1'b1, 1'b0);
            end else begin
                rst = 1'b1;
                cyc(1);
                rst = 1'b0;
                msg_len = 5'd2;
                push("reset_midrun", 4'b0000, 0, BLANKS,       1'b0, 1'b0);
                push("reset_idle",   4'b0000, 5, BLANKS,       1'b0, 1'b0);
                push("rs_start",     C_START, 1, BLANKS,       1'b1, 1'b0);
                push("buffer_kept",  4'b0000, 4, 32'hFFFFFFF9, 1'b1, 1'b0);
                push("rs_wrap",      4'b0000, 4, 32'hFFFFFF91, 1'b1, 1'b1);
            end
            while (sb.size() > 0) begin
                v = sb.pop_front();
                {start, stop, pause, step} = v.ctl;
                if (v.dly > 0) begin
                    cyc(1);
                    {start, stop, pause, step} = 4'b0000;
                    cyc(v.dly - 1);
                end
                vectors++;
                if (q !== v.q || busy !== v.busy || wrap !== v.wrap) begin
                    miscompares++;
                    $display("FAIL %s: got Q=%h busy=%b wrap=%b, expected Q=%h busy=%b wrap=%b",
                             v.name, q, busy, wrap, v.q, v.busy, v.wrap);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1);
    end

    initial begin
        logic [31:0] left_q;
        cyc(1);
        test_reset();
        test_basic_scroll();
        test_pause_step();
        test_simultaneous();
        test_invalid_restart();
        test_write_hazard(left_q);
        test_reset_midrun(left_q);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
